// File: rtl/cnnip_mem_arb_pkg.sv
// Shared types and helpers for the two-requester block-memory arbiter.
// Requester IDs are one bit wide and are stored in the in-order read tag queue.
package cnnip_mem_arb_pkg;

  typedef logic req_id_t;

  localparam int NUM_REQ = 2;

  function automatic int we_width(input int data_width);
    return ((data_width - 1) >> 3) + 1;
  endfunction

endpackage

// File: rtl/cnnip_mem_arb_tagq.sv
// In-order FIFO of requester IDs, one entry per outstanding read.
// The head entry names the requester that owns the next returning read word.
module cnnip_mem_arb_tagq
  import cnnip_mem_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rstn,
  input  logic    i_push,
  input  req_id_t i_push_id,
  input  logic    i_pop,
  output req_id_t o_head,
  output logic    o_full,
  output logic    o_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  req_id_t          r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == FULL_CNT);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_head  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_id;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= next_ptr(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= next_ptr(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/cnnip_mem_arbiter.sv
// Round-robin arbiter sharing one block-memory port between two CNN IP masters.
// Read responses are steered back to their issuer through an in-order tag queue.
module cnnip_mem_arbiter
  import cnnip_mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  localparam int WE_WIDTH = we_width(DATA_WIDTH),
  parameter int MAX_OUT = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  r0_en,
  input  logic [WE_WIDTH-1:0]   r0_we,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [DATA_WIDTH-1:0] r0_din,
  output logic                  r0_gnt,
  output logic [DATA_WIDTH-1:0] r0_dout,
  output logic                  r0_valid,
  input  logic                  r1_en,
  input  logic [WE_WIDTH-1:0]   r1_we,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0] r1_din,
  output logic                  r1_gnt,
  output logic [DATA_WIDTH-1:0] r1_dout,
  output logic                  r1_valid,
  output logic                  m_en,
  output logic [WE_WIDTH-1:0]   m_we,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [DATA_WIDTH-1:0] m_din,
  input  logic [DATA_WIDTH-1:0] m_dout,
  input  logic                  m_valid,
  output logic                  err,
  output logic                  busy
);

  logic [NUM_REQ-1:0] w_rd;
  logic [NUM_REQ-1:0] w_elig;
  logic [NUM_REQ-1:0] w_gnt;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  req_id_t            w_sel;
  req_id_t            w_head;
  req_id_t            r_last_gnt;
  logic               r_err;

  // Reads need a free tag slot judged on the registered count; writes always go.
  assign w_rd[0]   = r0_en & (r0_we == '0);
  assign w_rd[1]   = r1_en & (r1_we == '0);
  assign w_elig[0] = r0_en & (~w_rd[0] | ~w_full);
  assign w_elig[1] = r1_en & (~w_rd[1] | ~w_full);
  assign w_gnt[0]  = w_elig[0] & (~w_elig[1] | r_last_gnt);
  assign w_gnt[1]  = w_elig[1] & (~w_elig[0] | ~r_last_gnt);
  assign w_sel     = w_gnt[1];

  assign r0_gnt = w_gnt[0];
  assign r1_gnt = w_gnt[1];

  always_comb begin
    m_en   = |w_gnt;
    m_we   = '0;
    m_addr = r0_addr;
    m_din  = r0_din;
    if (w_gnt[1]) begin
      m_we   = r1_we;
      m_addr = r1_addr;
      m_din  = r1_din;
    end else if (w_gnt[0]) begin
      m_we = r0_we;
    end
  end

  assign w_push = |(w_gnt & w_rd);
  assign w_pop  = m_valid & ~w_empty;

  cnnip_mem_arb_tagq #(
    .DEPTH(MAX_OUT)
  ) u_tagq (
    .clk      (clk),
    .rstn     (rstn),
    .i_push   (w_push),
    .i_push_id(w_sel),
    .i_pop    (w_pop),
    .o_head   (w_head),
    .o_full   (w_full),
    .o_empty  (w_empty)
  );

  assign r0_valid = w_pop & (w_head == 1'b0);
  assign r1_valid = w_pop & (w_head == 1'b1);
  assign r0_dout  = m_dout;
  assign r1_dout  = m_dout;
  assign busy     = ~w_empty;
  assign err      = r_err;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_last_gnt <= 1'b1;
    end else if (|w_gnt) begin
      r_last_gnt <= w_sel;
    end
  end

  // A response with no tag outstanding has no owner; flag it until reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_err <= 1'b0;
    end else if (m_valid & w_empty) begin
      r_err <= 1'b1;
    end
  end

endmodule
